// File: rtl/instr_encoder.sv
// RV32I descriptor-to-machine-word encoder feeding the instruction memory write port.
// Optional immediate/kind range checker is enabled by defining ENC_CHECK_EN.
module instr_encoder #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_kind,
  input  logic [2:0]    in_funct3,
  input  logic          in_f7b5,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {K_LOAD, K_STORE, K_RTYPE, K_ITYPE, K_BRANCH} kind_t;

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  state_t      state, state_nxt;
  logic        accept;
  logic        session_start;
  logic [AW:0] count_inc;
  logic        reach_full;
  logic [31:0] enc_word;

  assign in_ready      = (state == S_RUN);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign accept        = in_valid & in_ready;
  assign session_start = (state == S_IDLE) & start;
  assign count_inc     = count + (AW+1)'(1);
  assign reach_full    = (count_inc == FULL_CNT);

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it holding its old value (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && (in_last || reach_full)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    enc_word = 32'h0000_0013;
    case (in_kind)
      K_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      K_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      K_RTYPE:  enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      K_ITYPE: begin
        case (in_funct3)
          3'b001:  enc_word = {7'b0000000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          3'b101:  enc_word = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          default: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        endcase
      end
      K_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
      default:  enc_word = 32'h0000_0013;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= accept;
      if (session_start) begin
        count <= '0;
        full  <= 1'b0;
      end
      if (accept) begin
        mem_addr  <= count[AW-1:0];
        mem_wdata <= enc_word;
        if (count != FULL_CNT) count <= count_inc;
        if (reach_full) full <= 1'b1;
      end
    end
  end

`ifdef ENC_CHECK_EN
  logic enc_bad;

  always_comb begin
    enc_bad = 1'b0;
    case (in_kind)
      K_LOAD, K_STORE:
        enc_bad = ($signed(in_imm) < -2048) || ($signed(in_imm) > 2047);
      K_RTYPE:
        enc_bad = 1'b0;
      K_ITYPE: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_bad = ($signed(in_imm) < 0) || ($signed(in_imm) > 31);
        else
          enc_bad = ($signed(in_imm) < -2048) || ($signed(in_imm) > 2047);
      end
      K_BRANCH:
        enc_bad = ($signed(in_imm) < -4096) || ($signed(in_imm) > 4094) || in_imm[0];
      default:
        enc_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                err <= 1'b0;
    else if (session_start)    err <= 1'b0;
    else if (accept && enc_bad) err <= 1'b1;
  end
`else
  // Upper immediate bits only matter to the range checker.
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:13];
  assign err           = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Converts RV32I instruction descriptors into 32-bit machine words and writes them sequentially into instruction memory.
- Sits between the testbench or host program source and the instruction memory write port.
- Covers exactly the instruction classes the main control decodes: load word, store word, R-type, I-type ALU and branch.
- Accepts one descriptor per cycle over a valid/ready handshake and runs a small load-session FSM with an address counter, full detection and an optional range checker.

## Interface
Parameters:
- AW, 6: instruction memory word-address width; DEPTH = 2^AW words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse in IDLE: begin session at word address 0.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- in_last  in  1  accompanying descriptor is the final one of the session.
- in_kind  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 ITYPE, 4 BRANCH; 5–7 invalid.
- in_funct3  in  3  funct3 field.
- in_f7b5  in  1  funct7[5] (SUB/SRA/SRAI select).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate (byte offset for BRANCH).
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  AW  word address.
- mem_wdata  out  32  encoded instruction.
- count  out  AW+1  words written this session.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse at end of session.
- full  out  1  sticky: session stopped because DEPTH words were written.
- err  out  1  sticky range/kind error (ENC_CHECK_EN only; else constant 0).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start: clears count, full and err.
  - RUN -> DONE when a descriptor is accepted with in_last=1, or when the accepted descriptor brings count to DEPTH (sets full).
  - DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
- in_ready = (state==RUN).
  - No backpressure from memory; the write always completes in one cycle.
- start is ignored outside IDLE. in_valid is ignored outside RUN.
- Encoding (imm = in_imm):
  - LOAD: {imm[11:0], rs1, f3, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - RTYPE: {0, f7b5, 00000, rs2, rs1, f3, rd, 0110011}.
  - ITYPE: {imm[11:0], rs1, f3, rd, 0010011}.
    - f3=001: upper 7 bits forced to 0000000.
    - f3=101: upper 7 bits forced to {0, f7b5, 00000}; shamt = imm[4:0].
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - Invalid kind: 0x00000013 (NOP).
- Immediates are truncated to field width; no arithmetic is performed on them.
- Each accept writes at mem_addr = count; count increments by 1. count never wraps, saturating at DEPTH.

## Timing
- Latency: accept at edge N -> mem_we=1 with mem_addr/mem_wdata during cycle N+1. Encoding is fully registered.
- Throughput: one word per cycle.
- If the final accept occurs at edge N, the last mem_we is in cycle N+1, coinciding with the DONE state (done=1).
- mem_we=0 in every cycle not directly following an accept.
- Reset values:
  - state IDLE.
  - mem_we, mem_addr, mem_wdata, count, done, full, err = 0.
  - in_ready and busy = 0.
- Reset mid-session: outputs take reset values at the next edge; any pending write is dropped (mem_we=0).
- Simultaneous in_last=1 and count reaching DEPTH: both sets of conditions apply; full=1 and a single DONE cycle.

## Configuration
- ENC_CHECK_EN defined: err sets at the edge after an accept of:
  - an invalid kind;
  - a LOAD/STORE/ITYPE (non-shift) imm outside [-2048, 2047];
  - an ITYPE shift imm outside [0, 31];
  - a BRANCH imm outside [-4096, 4094] or with imm[0]=1.
  - The word is still written, truncated.
- ENC_CHECK_EN undefined: no checker logic; err tied 0.

## Test plan
- start; lw x5,8(x1) -> mem_wdata 0x0080A283 at addr 0, one cycle after accept.
- Back-to-back sw x6,12(x2), sub x3,x1,x2, beq x1,x2,-4 (last) -> 0x00612623, 0x402081B3 and 0xFE208EE3 at addr 0–2 on consecutive cycles; done pulse with the third write; count=3.
- addi x1,x0,5 followed by srai (f3=101, f7b5=1, imm=3, rd=1, rs1=1) -> 0x00500093 then 0x4030D093.
- AW=2, five valid descriptors without in_last -> four writes to addr 0–3; in_ready low after the 4th accept; full=1; done pulse.
- ENC_CHECK_EN: lw x5,4096(x1) -> err=1, word 0x0000A283; kind=6 -> NOP 0x00000013, err=1; next start clears err.
- Assert rst_n low in the cycle after an accept -> mem_we=0 after that edge; state IDLE; count=0.
